ks_memory_responder: RTL
========================

// Module: ks_memory_responder
// PURPOSE
//  Memory-side responder for the K&S processor data path: 32x16 program/data RAM.
//  Serves the core's ram_addr / data_out / data_in bus.
//  Before execution, it holds the core and fills the RAM from a valid/ready program-load stream.
//  Sits between the top level (loader source) and the data path.
// PARAMETERS
//  ADDR_W  5   word-address width; must match the core's ram_addr width
//  DATA_W  16  word width; must match the core's data_in/data_out width
//  DEPTH   32  number of words; equals 2**ADDR_W
// PORTS
//  clk               in   1       rising-edge clock
//  rst_n             in   1       synchronous, active-low reset
//  ram_addr          in   ADDR_W  core word address
//  ram_wdata         in   DATA_W  core write data (core data_out)
//  ram_write_enable  in   1       core store strobe
//  ram_rdata         out  DATA_W  read data to core (core data_in)
//  core_hold         out  1       1 = core must not fetch or execute (loading)
//  reload            in   1       RUN-state pulse: return to LOAD
//  ld_valid          in   1       loader word valid
//  ld_data           in   DATA_W  loader word
//  ld_last           in   1       final loader word (qualified by ld_valid)
//  ld_ready          out  1       responder accepts a loader word
//  ld_count          out  6       words accepted in the current load, 0..32
//  loaded            out  1       1 = load complete, RUN state
// BEHAVIOUR
//  Reset, clk edge with rst_n=0:
//   - state=MS_LOAD; ld_ptr=0; ld_count=0; ram_rdata=0.
//   - Hence core_hold=1, ld_ready=1, loaded=0.
//   - RAM contents are NOT cleared.
//  Decoded outputs (from state, no added latency):
//   - core_hold = ld_ready = (state==MS_LOAD); loaded = (state==MS_RUN).
//  MS_LOAD:
//   - Beat = ld_valid & ld_ready. Each beat writes mem[ld_ptr] <= ld_data; ld_ptr++ and ld_count++.
//   - A beat with ld_last=1 moves to MS_RUN on the same edge.
//   - The 32nd beat (ld_ptr==DEPTH-1) moves to MS_RUN regardless of ld_last. No wrap; further words are never accepted.
//   - ld_valid=0 causes no change. Loader data is held by the source until ready (ld_ready is 1 throughout LOAD).
//   - Core writes are ignored; ram_rdata is held at 0.
//  MS_RUN:
//   - Read: ram_rdata <= mem[ram_addr] every edge (1-cycle latency). The address is sampled unregistered from the core.
//   - Write: ram_write_enable=1 -> mem[ram_addr] <= ram_wdata at the edge.
//   - Same-address read and write: read-first (ram_rdata returns old data); new data is visible on the next read.
//   - reload=1 -> next state MS_LOAD; ld_ptr=0, ld_count=0, ram_rdata=0.
//   - reload with a simultaneous ram_write_enable: the write completes, then LOAD.
//   - ld_valid in RUN is ignored (ld_ready=0).
//  Precedence: rst_n=0 > reload > normal operation.
//   - Reset mid-load restarts at address 0; previously written words stay until overwritten.
//  ld_ptr is ADDR_W bits; ld_count is ADDR_W+1 bits so it can show 32.
// STRUCTURE
//  k_and_s_pkg additions:
//   - localparams KS_ADDR_W=5, KS_DATA_W=16, KS_MEM_DEPTH=32.
//   - typedef enum logic {MS_LOAD, MS_RUN} mem_state_t.
//  Sub-module ks_sync_ram: one write port and one registered, read-first read port.
//   - Write port is muxed between loader and core by state.
//   - Read enable is active in RUN only, plus a synchronous clear for the rdata register.
//  Top of this block holds only the FSM, pointer/counter and port muxing.
// TESTING
//  1. Reset; load 0x8105, 0xA155, 0xFF00 (ld_last on 3rd) -> ld_count=3, loaded=1 and core_hold=0 after 3rd edge;
//     addr 0 -> ram_rdata=0x8105 one cycle later; addr 2 -> 0xFF00.
//  2. Load 32 words 0x0100+i with ld_last never set -> RUN after the 32nd beat, ld_count=32, ld_ready=0;
//     a 33rd ld_valid is not accepted; addr 31 reads 0x011F.
//  3. RUN: write addr 7 = 0x1234 while reading addr 7 -> ram_rdata = old mem[7];
//     next-cycle read of addr 7 -> 0x1234.
//  4. During LOAD, drive ram_write_enable=1, addr 0, 0xDEAD -> after load, addr 0 reads the loaded word, not 0xDEAD;
//     ram_rdata=0 throughout LOAD.
//  5. rst_n=0 after 2 beats of a 4-word load -> ld_count=0, core_hold=1;
//     reload of 1 word 0x0001 with ld_last -> addr 0=0x0001, addr 1 keeps the pre-reset word.
//  6. RUN: reload=1 together with a write of 0x5555 to addr 3 -> LOAD, ld_count=0, ram_rdata=0;
//     after a 1-word reload, addr 3 reads 0x5555.

Source files
------------

// File: rtl/ks_memory_responder_pkg.sv
// Shared sizing and state encoding for the K&S memory responder.
// The memory geometry must track the core's ram_addr and data bus widths.
package ks_memory_responder_pkg;

  localparam int KS_ADDR_W    = 5;
  localparam int KS_DATA_W    = 16;
  localparam int KS_MEM_DEPTH = 32;

  typedef enum logic {
    MS_LOAD = 1'b0,
    MS_RUN  = 1'b1
  } mem_state_t;

endpackage

// File: rtl/ks_memory_responder_sync_ram.sv
// Single-port-write, registered read-first RAM for the K&S memory responder.
// The read register has its own synchronous clear so it can be parked at zero.
module ks_sync_ram #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              clr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Storage write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read register: nonblocking read of the array gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (clr) begin
      rdata_r <= DATA_W'(0);
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/ks_memory_responder.sv
// Memory-side responder for the K&S data path: holds the core while a program
// is streamed in, then serves core reads/writes from the same RAM.
module ks_memory_responder
  import ks_memory_responder_pkg::*;
#(
  parameter int ADDR_W = KS_ADDR_W,
  parameter int DATA_W = KS_DATA_W,
  parameter int DEPTH  = KS_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_write_enable,
  output logic [DATA_W-1:0] ram_rdata,
  output logic              core_hold,
  input  logic              reload,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic [ADDR_W:0]   ld_count,
  output logic              loaded
);

  mem_state_t        state_r, state_nxt_s;
  logic [ADDR_W-1:0] ld_ptr_r, ld_ptr_nxt_s;
  logic [ADDR_W:0]   ld_count_r, ld_count_nxt_s;
  logic              in_load_s, in_run_s, beat_s, reload_s;
  logic              mem_we_s, rd_clr_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  assign in_load_s = (state_r == MS_LOAD);
  assign in_run_s  = (state_r == MS_RUN);
  assign beat_s    = ld_valid & in_load_s;
  assign reload_s  = reload & in_run_s;

  // Next-state, load pointer and beat counter.
  always_comb begin
    state_nxt_s    = state_r;
    ld_ptr_nxt_s   = ld_ptr_r;
    ld_count_nxt_s = ld_count_r;
    case (state_r)
      MS_LOAD: begin
        if (beat_s) begin
          ld_ptr_nxt_s   = ld_ptr_r + ADDR_W'(1);
          ld_count_nxt_s = ld_count_r + (ADDR_W + 1)'(1);
          // The last slot ends the load even without ld_last: no wrap.
          if (ld_last || (ld_ptr_r == ADDR_W'(DEPTH - 1))) begin
            state_nxt_s = MS_RUN;
          end else begin
            state_nxt_s = MS_LOAD;
          end
        end else begin
          state_nxt_s = MS_LOAD;
        end
      end
      MS_RUN: begin
        if (reload_s) begin
          state_nxt_s    = MS_LOAD;
          ld_ptr_nxt_s   = ADDR_W'(0);
          ld_count_nxt_s = (ADDR_W + 1)'(0);
        end else begin
          state_nxt_s = MS_RUN;
        end
      end
      default: begin
        state_nxt_s    = MS_LOAD;
        ld_ptr_nxt_s   = ADDR_W'(0);
        ld_count_nxt_s = (ADDR_W + 1)'(0);
      end
    endcase
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= MS_LOAD;
      ld_ptr_r   <= ADDR_W'(0);
      ld_count_r <= (ADDR_W + 1)'(0);
    end else begin
      state_r    <= state_nxt_s;
      ld_ptr_r   <= ld_ptr_nxt_s;
      ld_count_r <= ld_count_nxt_s;
    end
  end

  // Write-port ownership: loader during LOAD, core during RUN.
  always_comb begin
    if (in_load_s) begin
      mem_we_s    = rst_n & beat_s;
      mem_waddr_s = ld_ptr_r;
      mem_wdata_s = ld_data;
    end else begin
      mem_we_s    = rst_n & ram_write_enable;
      mem_waddr_s = ram_addr;
      mem_wdata_s = ram_wdata;
    end
  end

  assign rd_clr_s = ~rst_n | in_load_s | reload_s;

  ks_sync_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (mem_waddr_s),
    .wdata (mem_wdata_s),
    .re    (in_run_s),
    .raddr (ram_addr),
    .clr   (rd_clr_s),
    .rdata (ram_rdata)
  );

  assign core_hold = in_load_s;
  assign ld_ready  = in_load_s;
  assign loaded    = in_run_s;
  assign ld_count  = ld_count_r;

endmodule
